// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encodings and default datapath width for the ALU
package alu_pkg;
    localparam int DEFAULT_WIDTH = 32;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational result and flag computation for one ALU operation
module alu_core import alu_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);
    localparam int SW = $clog2(WIDTH);
    logic             sub;
    logic             arith;
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   sum;
    logic [SW-1:0]    sh;
    // SUB reuses the adder as a + ~b + 1 so carry means "no borrow"
    always_comb begin
        sub      = opcode == OP_SUB;
        arith    = sub || opcode == OP_ADD;
        bx       = sub ? ~b : b;
        sum      = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
        sh       = b[SW-1:0];
        result   = arith            ? sum[WIDTH-1:0] :
                   opcode == OP_AND ? a & b :
                   opcode == OP_OR  ? a | b :
                   opcode == OP_XOR ? a ^ b :
                   opcode == OP_NOT ? ~a :
                   opcode == OP_SHL ? a << sh : a >> sh;
        carry    = arith && sum[WIDTH];
        overflow = arith && (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        zero     = result == '0;
    end
endmodule

// File: rtl/alu_32.sv
// alu_32: registered ALU with enable-gated capture and one-cycle latency
module alu_32 import alu_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       opcode,
    input  logic             enable,
    output logic [WIDTH-1:0] Result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             valid
);
    logic [WIDTH-1:0] nxt_result;
    logic             nxt_zero;
    logic             nxt_carry;
    logic             nxt_overflow;

    alu_core #(.WIDTH(WIDTH)) core (
        .a(A),
        .b(B),
        .opcode(opcode),
        .result(nxt_result),
        .zero(nxt_zero),
        .carry(nxt_carry),
        .overflow(nxt_overflow)
    );

    // capture the operation when enabled; otherwise hold outputs and drop valid
    always_ff @(posedge clk) begin
        if (rst) begin
            Result   <= '0;
            zero     <= 1'b1;
            carry    <= 1'b0;
            overflow <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= enable;
            if (enable) begin
                Result   <= nxt_result;
                zero     <= nxt_zero;
                carry    <= nxt_carry;
                overflow <= nxt_overflow;
            end
        end
    end
endmodule

// File: tb/tb_alu_32.sv
// tb_alu_32: directed and randomized checks of alu_32 against an arithmetic model
module tb_alu_32;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  opcode;
    logic        enable;
    logic [31:0] Result;
    logic        zero;
    logic        carry;
    logic        overflow;
    logic        valid;
    int checks = 0;
    int errors = 0;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;
    localparam longint TWO32 = 64'sd4294967296;

    always #5 clk = ~clk;

    alu_32 #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .A(A),
        .B(B),
        .opcode(opcode),
        .enable(enable),
        .Result(Result),
        .zero(zero),
        .carry(carry),
        .overflow(overflow),
        .valid(valid)
    );

    // returns {result, zero, carry, overflow} from integer arithmetic
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint full = 0;
        longint s = 0;
        logic [4:0] amt = b[4:0];
        logic [31:0] r;
        logic c = 1'b0;
        logic o = 1'b0;
        case (op)
            3'd0: begin full = ua + ub; c = full >= TWO32; s = sa + sb; o = s > SMAX || s < SMIN; end
            3'd1: begin full = ua - ub; c = ua >= ub; s = sa - sb; o = s > SMAX || s < SMIN; end
            3'd2: full = ua & ub;
            3'd3: full = ua | ub;
            3'd4: full = ua ^ ub;
            3'd5: full = (TWO32 - 1) - ua;
            3'd6: full = ua << amt;
            default: full = ua >> amt;
        endcase
        r = full[31:0];
        return {r, r == 32'd0, c, o};
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input logic en);
        A = a;
        B = b;
        opcode = op;
        enable = en;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(32'd15, 32'd15, 3'd0, 1'b1);
        drive(32'd15, 32'd15, 3'd0, 1'b1);
        checks++;
        if ({Result, zero, carry, overflow, valid} !== {32'd0, 1'b1, 3'b000}) begin
            errors++;
            $display("FAIL reset: got R=%h z%b c%b o%b v%b, want R=0 z1 c0 o0 v0", Result, zero, carry, overflow, valid);
        end
        rst = 1'b0;
    endtask

    task automatic test_opcode_sweep;
        logic [31:0] exp_r [8] = '{32'd30, 32'd0, 32'd15, 32'd15, 32'd0, 32'hFFFFFFF0, 32'h00078000, 32'd0};
        for (int i = 0; i < 8; i++) begin
            drive(32'd15, 32'd15, 3'(i), 1'b1);
            checks++;
            if ({Result, zero, carry, overflow, valid} !== {exp_r[i], exp_r[i] == 32'd0, i == 1, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL sweep op%0d: got R=%h z%b c%b o%b v%b, want R=%h z%b c%b o0 v1",
                         i, Result, zero, carry, overflow, valid, exp_r[i], exp_r[i] == 32'd0, i == 1);
            end
        end
    endtask

    task automatic test_hold;
        drive(32'd15, 32'd15, 3'd0, 1'b1);
        drive(32'd15, 32'd15, 3'd4, 1'b0);
        checks++;
        if ({Result, zero, valid} !== {32'd30, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL hold: got R=%h z%b v%b, want R=1e z0 v0", Result, zero, valid);
        end
        drive(32'd15, 32'd15, 3'd4, 1'b0);
        checks++;
        if ({Result, valid} !== {32'd30, 1'b0}) begin
            errors++;
            $display("FAIL hold2: got R=%h v%b, want R=1e v0", Result, valid);
        end
        drive(32'd15, 32'd15, 3'd4, 1'b1);
        checks++;
        if ({Result, zero, valid} !== {32'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL hold_resume: got R=%h z%b v%b, want R=0 z1 v1", Result, zero, valid);
        end
    endtask

    task automatic test_add_edges;
        drive(32'hFFFFFFFF, 32'd1, 3'd0, 1'b1);
        checks++;
        if ({Result, zero, carry, overflow} !== {32'd0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL add_wrap: got R=%h z%b c%b o%b, want R=0 z1 c1 o0", Result, zero, carry, overflow);
        end
        drive(32'h7FFFFFFF, 32'd1, 3'd0, 1'b1);
        checks++;
        if ({Result, zero, carry, overflow} !== {32'h80000000, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL add_ovf: got R=%h z%b c%b o%b, want R=80000000 z0 c0 o1", Result, zero, carry, overflow);
        end
    endtask

    task automatic test_sub_edges;
        drive(32'd0, 32'd1, 3'd1, 1'b1);
        checks++;
        if ({Result, carry, overflow} !== {32'hFFFFFFFF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sub_borrow: got R=%h c%b o%b, want R=ffffffff c0 o0", Result, carry, overflow);
        end
        drive(32'h80000000, 32'd1, 3'd1, 1'b1);
        checks++;
        if ({Result, carry, overflow} !== {32'h7FFFFFFF, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL sub_ovf: got R=%h c%b o%b, want R=7fffffff c1 o1", Result, carry, overflow);
        end
    endtask

    task automatic test_shift_mask;
        drive(32'd1, 32'hFFFFFFE1, 3'd6, 1'b1);
        checks++;
        if ({Result, carry, overflow} !== {32'd2, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL shl_mask: got R=%h c%b o%b, want R=2 c0 o0", Result, carry, overflow);
        end
        drive(32'hA5A5A5A5, 32'h00000020, 3'd7, 1'b1);
        checks++;
        if (Result !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL shr_zero_amt: got R=%h, want R=a5a5a5a5", Result);
        end
        drive(32'h80000000, 32'd31, 3'd7, 1'b1);
        checks++;
        if (Result !== 32'd1) begin
            errors++;
            $display("FAIL shr_31: got R=%h, want R=1", Result);
        end
    endtask

    task automatic test_reset_priority;
        drive(32'd5, 32'd5, 3'd0, 1'b1);
        rst = 1'b1;
        drive(32'd1, 32'd2, 3'd0, 1'b1);
        checks++;
        if ({Result, zero, valid} !== {32'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_priority: got R=%h z%b v%b, want R=0 z1 v0", Result, zero, valid);
        end
        rst = 1'b0;
        drive(32'd1, 32'd2, 3'd0, 1'b1);
        checks++;
        if ({Result, zero, valid} !== {32'd3, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_resume: got R=%h z%b v%b, want R=3 z0 v1", Result, zero, valid);
        end
    endtask

    task automatic test_random;
        logic [34:0] held;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        en;
        drive(32'd0, 32'd0, 3'd2, 1'b1);
        held = model(32'd0, 32'd0, 3'd2);
        for (int i = 0; i < 400; i++) begin
            a  = (i % 5 == 0) ? {$urandom_range(1) == 1, 31'h7FFFFFFF} ^ 32'($urandom_range(3)) : $urandom;
            b  = (i % 7 == 0) ? 32'($urandom_range(40)) : $urandom;
            op = 3'($urandom_range(7));
            en = $urandom_range(3) != 0;
            drive(a, b, op, en);
            if (en) held = model(a, b, op);
            checks++;
            if ({Result, zero, carry, overflow, valid} !== {held, en}) begin
                errors++;
                $display("FAIL random[%0d] op%0d a=%h b=%h en%b: got R=%h z%b c%b o%b v%b, want R=%h z%b c%b o%b v%b",
                         i, op, a, b, en, Result, zero, carry, overflow, valid,
                         held[34:3], held[2], held[1], held[0], en);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        A = '0;
        B = '0;
        opcode = '0;
        enable = 1'b0;
        test_reset();
        test_opcode_sweep();
        test_hold();
        test_add_edges();
        test_sub_edges();
        test_shift_mask();
        test_reset_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_32.md
ALU_32 -- requirements
Module: alu_32

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of operands and result.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port rst  input  1  synchronous active-high reset.
REQ-004 Port A  input  WIDTH  operand A, unsigned/two's-complement bit vector.
REQ-005 Port B  input  WIDTH  operand B; B[log2(WIDTH)-1:0] is the shift amount for shifts.
REQ-006 Port opcode  input  3  operation select.
REQ-007 Port enable  input  1  when high, the operation is captured at the next clk edge.
REQ-008 Port Result  output  WIDTH  registered operation result.
REQ-009 Port zero  output  1  registered flag; high when the captured result equals 0.
REQ-010 Port carry  output  1  registered carry/no-borrow flag.
REQ-011 Port overflow  output  1  registered signed-overflow flag.
REQ-012 Port valid  output  1  registered; high for one cycle after each cycle with enable high.

Function
REQ-013 The opcode map SHALL be: 000 ADD A+B; 001 SUB A-B; 010 AND; 011 OR; 100 XOR; 101 NOT A (B ignored); 110 SHL A by B[4:0] (logical); 111 SHR A by B[4:0] (logical, zero fill).
REQ-014 Result SHALL be the low WIDTH bits of the operation; excess bits are discarded (modulo 2^WIDTH wrap).
REQ-015 Latency SHALL be exactly one clock: inputs sampled at edge N appear on Result and the flags after edge N.
REQ-016 When enable is low at an edge, Result, zero, carry and overflow SHALL hold their previous values, and valid SHALL be 0.
REQ-017 For ADD, carry SHALL be the carry-out of A+B, and overflow SHALL be set when the operands share a sign bit and the sign of Result differs from it.
REQ-018 For SUB, carry SHALL be the carry-out of A+~B+1 (1 when A>=B unsigned), and overflow SHALL be set when the operand signs differ and the sign of Result differs from A.
REQ-019 For opcodes 010-111, carry and overflow SHALL be 0.
REQ-020 zero SHALL be computed from the same result value that is written to Result.
REQ-021 A shift amount of 0 SHALL pass A unchanged; shifts use only the B[4:0] bits, and higher bits of B are ignored.
REQ-022 The block SHALL have no combinational path from the inputs to the outputs.

Reset
REQ-023 While rst is high at a clk edge, Result SHALL become 0, zero 1, and carry, overflow and valid 0, regardless of enable.
REQ-024 rst SHALL take priority over enable; an operation presented in the same cycle as reset is discarded.
REQ-025 On the first edge with rst low and enable high, normal operation SHALL resume with one-cycle latency.

Structure
REQ-026 The opcode encodings (OP_ADD ... OP_SHR) and WIDTH default SHALL be localparams in a shared package alu_pkg.
REQ-027 A combinational sub-module alu_core SHALL compute the next result and flags; alu_32 SHALL register them and handle enable and reset.

Verification
REQ-028 Hold rst high with enable=1, A=15, B=15, opcode=000 -> Result=0, zero=1, valid=0.
REQ-029 With A=B=15 and enable=1, issue opcodes 000 through 111 on consecutive cycles -> Result is 30, 0 (zero=1, carry=1), 15, 15, 0 (zero=1), 0xFFFFFFF0, 0x00078000, 0, each one cycle after its opcode.
REQ-030 enable=0, A=B=15, opcode=100 after an ADD result of 30 -> Result stays 30 and valid=0; raising enable then gives Result=0 and zero=1.
REQ-031 ADD with A=0xFFFFFFFF, B=1 -> Result=0, carry=1, zero=1, overflow=0; ADD with A=0x7FFFFFFF, B=1 -> Result=0x80000000, overflow=1, carry=0.
REQ-032 SUB with A=0, B=1 -> Result=0xFFFFFFFF, carry=0; SUB with A=0x80000000, B=1 -> Result=0x7FFFFFFF, overflow=1.
REQ-033 SHL with A=1, B=0xFFFFFFE1 -> Result=2, showing that only B[4:0]=1 is used.
